// File: rtl/debounce_pkg.sv
// Shared request-bus types and defaults for the debouncer and the priority encoder it feeds.
package debounce_pkg;

    localparam int REQ_WIDTH             = 3;
    localparam int DEFAULT_STABLE_CYCLES = 4;

    typedef logic [REQ_WIDTH-1:0] req_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop metastability synchronizer, one independent chain per bit, async active-high reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_meta[gi] <= 1'b0;
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_meta[gi] <= d[gi];
                    r_sync[gi] <= r_meta[gi];
                end
            end
        end
    endgenerate

    assign q = r_sync;

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces the raw request lines ahead of the priority encoder.
// Define INPUT_DEBOUNCER_SYNC2_EN to use a two-flop synchronizer instead of a single sampling flop.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH         = REQ_WIDTH,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] a_out,
    output logic             change_pulse,
    output logic             stable
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 2) begin : g_bad_param
            $error("input_debouncer: STABLE_CYCLES must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] w_samp;
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_out;
    logic             r_pulse;

`ifdef INPUT_DEBOUNCER_SYNC2_EN
    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (w_samp)
    );
`else
    logic [WIDTH-1:0] r_samp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp <= '0;
        end else begin
            r_samp <= raw_in;
        end
    end

    assign w_samp = r_samp;
`endif

    // Any change in the sample restarts the window, even on the edge the count would saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand  <= '0;
            r_cnt   <= '0;
            r_a_out <= '0;
            r_pulse <= 1'b0;
        end else if (w_samp != r_cand) begin
            r_cand  <= w_samp;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (r_cnt < CNT_MAX) begin
            r_cnt   <= r_cnt + 1'b1;
            r_pulse <= 1'b0;
        end else if (r_cand != r_a_out) begin
            r_a_out <= r_cand;
            r_pulse <= 1'b1;
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign a_out        = r_a_out;
    assign change_pulse = r_pulse;
    assign stable       = (r_cnt == CNT_MAX) && (r_cand == r_a_out);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed and randomized checks of input_debouncer against a sample-history reference model.
module tb_input_debouncer;

    localparam int W = 3;
    localparam int S = 4;
`ifdef INPUT_DEBOUNCER_SYNC2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int LAT = S + D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] a_out;
    logic         change_pulse;
    logic         stable;

    int compared   = 0;
    int mismatched = 0;

    input_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_in       (raw_in),
        .a_out        (a_out),
        .change_pulse (change_pulse),
        .stable       (stable)
    );

    always #5 clk = ~clk;

    // Reference model: acceptance means the last S+1 synchronized samples agree and differ from
    // the held value; stability means the last S samples agree with the held value.
    logic [W-1:0] m_pipe [D];
    logic [W-1:0] m_hist [$];
    logic [W-1:0] m_a;
    logic         m_pulse;
    logic         m_stable;
    logic         prev_pulse;
    int           pulse_cnt;

    function automatic bit last_equal(int n);
        if (m_hist.size() < n) return 0;
        for (int k = m_hist.size() - n; k < m_hist.size(); k++)
            if (m_hist[k] !== m_hist[m_hist.size() - 1]) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) m_pipe[k] = '0;
        m_hist.delete();
        m_hist.push_back('0);
        m_a      = '0;
        m_pulse  = 1'b0;
        m_stable = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] raw_at);
        logic [W-1:0] s;
        s = m_pipe[D-1];
        m_hist.push_back(s);
        if (m_hist.size() > S + 1) void'(m_hist.pop_front());
        if (last_equal(S + 1) && s !== m_a) begin
            m_a     = s;
            m_pulse = 1'b1;
        end else begin
            m_pulse = 1'b0;
        end
        m_stable = last_equal(S) && (s === m_a);
        for (int k = D - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = raw_at;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".a_out"}, 32'(a_out), 32'(m_a));
        chk({tag, ".change_pulse"}, 32'(change_pulse), 32'(m_pulse));
        chk({tag, ".stable"}, 32'(stable), 32'(m_stable));
    endtask

    task automatic step(input string tag);
        logic [W-1:0] raw_at;
        logic         rst_at;
        @(posedge clk);
        raw_at = raw_in;
        rst_at = rst;
        if (rst_at) model_reset();
        else model_edge(raw_at);
        #1;
        check_outputs(tag);
        chk({tag, ".pulse_spacing"}, 32'(prev_pulse & change_pulse), 32'd0);
        prev_pulse = change_pulse;
        if (change_pulse === 1'b1) pulse_cnt++;
        $display("[%0t] %s rst=%b raw=%b a_out=%b pulse=%b stable=%b", $time, tag, rst_at, raw_at,
                 a_out, change_pulse, stable);
    endtask

    // Holds raw_in at val and returns the edge index (E0 = first edge) at which a_out first equals val.
    task automatic hold_until(input string tag, input logic [W-1:0] val, input int budget,
                              output int first);
        raw_in = val;
        first  = -1;
        for (int i = 0; i < budget; i++) begin
            step(tag);
            if (first < 0 && a_out === val) first = i;
        end
    endtask

    initial begin
        int first;
        int seg;
        logic [W-1:0] v;

        model_reset();
        prev_pulse = 1'b0;
        pulse_cnt  = 0;

        // Reset held for 3 edges with raw_in = 000, then released.
        rst = 1'b1;
        raw_in = '0;
        for (int i = 0; i < 3; i++) step("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step("reset_release");
        chk("reset.stable_after_5", 32'(stable), 32'd1);

        // Clean change 000 -> 010.
        pulse_cnt = 0;
        hold_until("clean", 3'b010, 12, first);
        chk("clean.latency", 32'(first), 32'(LAT));
        chk("clean.pulses", 32'(pulse_cnt), 32'd1);

        // Glitch of 3 cycles must be rejected.
        pulse_cnt = 0;
        raw_in = 3'b101;
        for (int i = 0; i < 3; i++) step("glitch");
        raw_in = 3'b010;
        for (int i = 0; i < 10; i++) step("glitch_recover");
        chk("glitch.a_out", 32'(a_out), 32'(3'b010));
        chk("glitch.pulses", 32'(pulse_cnt), 32'd0);

        // Bounce 101/010 every 2 cycles for 12 cycles, then settle at 101.
        pulse_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            raw_in = (i % 2 == 0) ? 3'b101 : 3'b010;
            for (int j = 0; j < 2; j++) step("bounce");
        end
        chk("bounce.a_out_held", 32'(a_out), 32'(3'b010));
        hold_until("bounce_settle", 3'b101, 12, first);
        chk("bounce.latency", 32'(first), 32'(LAT));
        chk("bounce.pulses", 32'(pulse_cnt), 32'd1);

        // Reset asserted asynchronously mid-count.
        raw_in = 3'b111;
        step("midrst_count");
        step("midrst_count");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("midrst_async");
        step("midrst_hold");
        step("midrst_hold");
        rst = 1'b0;
        pulse_cnt = 0;
        hold_until("midrst_release", 3'b111, 12, first);
        chk("midrst.latency", 32'(first), 32'(LAT));
        chk("midrst.pulses", 32'(pulse_cnt), 32'd1);

        // Randomized segments of random length.
        for (int n = 0; n < 60; n++) begin
            v   = W'($urandom_range(0, 7));
            seg = int'($urandom_range(1, 8));
            raw_in = v;
            for (int j = 0; j < seg; j++) step("random");
        end

        // Continuous toggling never changes a_out.
        v = a_out;
        for (int i = 0; i < 20; i++) begin
            raw_in = ~raw_in;
            step("toggle");
        end
        chk("toggle.a_out_held", 32'(a_out), 32'(v));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
